// File: rtl/irq_controller_if.sv
// ---------------------------------------------------------------------------
// irq_controller_if
//   Bundles the signals between the interrupt controller and the core.
//   master : core / environment side (drives requests, masks, PC, MRET)
//   slave  : interrupt controller side (drives interrupt, vector, ISR state)
//   Signals:
//     irq_in, irq_enable   NUM_IRQ  request lines and per-line enable mask
//     gie                  1        global interrupt enable
//     boundary             1        core is at an instruction start
//     mret                 1        MRET commits this cycle
//     pc_new               16       current program counter
//     interrupt            1        take interrupt this cycle
//     isr_target           16       vector of the selected line
//     isr_return           16       saved return address
//     in_isr               1        ISR active
//     irq_cause            CW       index of the line taken last
//     irq_pending          NUM_IRQ  latched pending bits
// ---------------------------------------------------------------------------
interface irq_controller_if #(
    parameter int NUM_IRQ = 4
);
    localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_enable;
    logic               gie;
    logic               boundary;
    logic               mret;
    logic [15:0]        pc_new;
    logic               interrupt;
    logic [15:0]        isr_target;
    logic [15:0]        isr_return;
    logic               in_isr;
    logic [CW-1:0]      irq_cause;
    logic [NUM_IRQ-1:0] irq_pending;

    modport master (
        output irq_in, irq_enable, gie, boundary, mret, pc_new,
        input  interrupt, isr_target, isr_return, in_isr, irq_cause, irq_pending
    );

    modport slave (
        input  irq_in, irq_enable, gie, boundary, mret, pc_new,
        output interrupt, isr_target, isr_return, in_isr, irq_cause, irq_pending
    );
endinterface

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Latches rising edges on the interrupt lines, picks the lowest-index
//   enabled pending line and, at an instruction boundary, requests the core
//   to jump to that line's vector. Captures the return PC and blocks further
//   interrupts until MRET commits (no nesting).
//
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous, active-low reset
//     bus    slave modport of irq_controller_if (see that file)
//
//   Optional build macro:
//     IRQCTRL_SYNC_EN  adds a 2-flop synchronizer (reset to ones) on each
//                      irq_in line ahead of edge detection (+2 cycles).
// ---------------------------------------------------------------------------
module irq_controller #(
    parameter int          NUM_IRQ       = 4,
    parameter logic [15:0] VECTOR_BASE   = 16'h0100,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0010
) (
    input  logic              clk,
    input  logic              reset,
    irq_controller_if.slave   bus
);
    localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [15:0]        ret_q, ret_d;
    logic [CW-1:0]      cause_q, cause_d;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] qualified;
    logic [NUM_IRQ-1:0] clear_mask;
    logic [CW-1:0]      sel;
    logic               take;
    logic               in_isr;

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
`ifdef IRQCTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = bus.irq_in;
        sync2_d = sync1_q;
    end

    // Reset to ones so a line already high at reset release looks "old".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = bus.irq_in;
`endif

    // -----------------------------------------------------------------------
    // Edge detect, priority select, vector
    // -----------------------------------------------------------------------
    assign rise      = irq_s & ~prev_q;
    assign qualified = pending_q & bus.irq_enable;

    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    always_comb begin
        sel = '0;
        // Scan high to low so the lowest qualifying index wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (qualified[i]) sel = CW'(i);
        end
    end

    // 16-bit context: the vector wraps modulo 2^16.
    assign bus.isr_target = VECTOR_BASE + 16'(sel) * VECTOR_STRIDE;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (take)     state_d = ACTIVE;
            ACTIVE: if (bus.mret) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_isr = (state_q == ACTIVE);
        take   = bus.boundary & bus.gie & ~in_isr & (|qualified);
    end

    assign bus.interrupt = take;
    assign bus.in_isr    = in_isr;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_comb begin
        clear_mask = take ? (NUM_IRQ'(1) << sel) : '0;
        prev_d     = irq_s;
        // Set wins over clear: a fresh edge on the taken line stays pending.
        pending_d  = (pending_q & ~clear_mask) | rise;
        ret_d      = take ? bus.pc_new : ret_q;
        cause_d    = take ? sel        : cause_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q    <= '1;
            pending_q <= '0;
            ret_q     <= '0;
            cause_q   <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            ret_q     <= ret_d;
            cause_q   <= cause_d;
        end
    end

    assign bus.isr_return  = ret_q;
    assign bus.irq_cause   = cause_q;
    assign bus.irq_pending = pending_q;

endmodule
